spart_word_rx: RTL and testbench

Receive-side companion to the SPART transmit path. Deserializes 8N1 asynchronous bytes from `rxd`, assembles four consecutive bytes into a 32-bit word and raises a level interrupt to the board logic. It sits between the serial pin and the core's receive-word consumer and needs no bus driver or config registers.

---
 rtl/spart_word_rx.sv | 165 ++++++++++++++++
 tb/tb_spart_word_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spart_word_rx.sv
// SPART receive path: 8N1 deserializer plus 4-byte little-endian word assembler with level interrupt.
// Optional partial-word idle timeout is enabled by defining SPART_WORD_TIMEOUT_EN.
module spart_word_rx #(
  parameter int BAUD_DIV     = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        clr,
  output logic [31:0] rx_data,
  output logic        interrupt_board,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          byte_ok, byte_bad;
  logic          rx_meta, rxs;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_buf;
  logic          timeout_hit;
  logic          busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    byte_ok     = 1'b0;
    byte_bad    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          cnt_nxt   = CW'(BAUD_DIV / 2 - 1);
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt     = CW'(BAUD_DIV - 1);
            bit_idx_nxt = '0;
            state_nxt   = S_DATA;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shreg_nxt   = {rxs, shreg[7:1]};
          cnt_nxt     = CW'(BAUD_DIV - 1);
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (rxs) byte_ok = 1'b1;
          else     byte_bad = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SPART_WORD_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW = $clog2(TO_LIMIT + 1);

  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (state == S_IDLE) && (byte_cnt != '0) && (idle_cnt == TW'(TO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   idle_cnt <= '0;
    else if (state != S_IDLE || byte_cnt == '0)   idle_cnt <= '0;
    else if (timeout_hit)                         idle_cnt <= '0;
    else                                          idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A clr arriving with a completing word frees the slot, so the new word is taken, not dropped.
  assign busy = interrupt_board & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data         <= '0;
      interrupt_board <= 1'b0;
      frame_err       <= 1'b0;
      overrun         <= 1'b0;
      byte_cnt        <= '0;
      word_buf        <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (clr) interrupt_board <= 1'b0;
      if (byte_bad) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
      end else if (byte_ok) begin
        if (byte_cnt == 2'd3) begin
          byte_cnt <= '0;
          if (!busy) begin
            rx_data         <= {shreg, word_buf};
            interrupt_board <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          case (byte_cnt)
            2'd0:    word_buf[7:0]   <= shreg;
            2'd1:    word_buf[15:8]  <= shreg;
            default: word_buf[23:16] <= shreg;
          endcase
        end
      end else if (timeout_hit) begin
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spart_word_rx.sv
// Directed bench for spart_word_rx at BAUD_DIV=16; frames are driven on falling clock edges.
module tb_spart_word_rx;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] rx_data;
  logic        interrupt_board;
  logic        frame_err;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  logic irq_pre, irq_post, fe_post, fe_after, ov_post, ov_after;

  spart_word_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(20)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rxd             (rxd),
    .clr             (clr),
    .rx_data         (rx_data),
    .interrupt_board (interrupt_board),
    .frame_err       (frame_err),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Pin falls at negedge 0; the stop sample completes on the posedge just before negedge 155.
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic clr_done);
    for (int i = 0; i < 10 * BD; i++) begin
      int slot;
      slot = i / BD;
      if (slot == 0)      rxd = 1'b0;
      else if (slot == 9) rxd = stop;
      else                rxd = d[slot-1];
      if (i == 154) begin
        irq_pre = interrupt_board;
        if (clr_done) clr = 1'b1;
      end
      if (i == 155) begin
        irq_post = interrupt_board;
        fe_post  = frame_err;
        ov_post  = overrun;
        clr      = 1'b0;
      end
      if (i == 156) begin
        fe_after = frame_err;
        ov_after = overrun;
      end
      @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic clr_done);
    logic [31:0] wv;
    wv = w;
    send_byte(wv[7:0],   1'b1, 1'b0);
    send_byte(wv[15:8],  1'b1, 1'b0);
    send_byte(wv[23:16], 1'b1, 1'b0);
    send_byte(wv[31:24], 1'b1, clr_done);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] pd;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 32'h0);
    chk("reset_irq", {31'b0, interrupt_board}, 32'h0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'h0);
    chk("reset_overrun", {31'b0, overrun}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    send_word(32'h12345678, 1'b0);
    chk("w1_irq_before_edge", {31'b0, irq_pre}, 32'h0);
    chk("w1_irq_after_edge", {31'b0, irq_post}, 32'h1);
    chk("w1_rx_data", rx_data, 32'h12345678);
    pulse_clr();
    chk("w1_clr_irq", {31'b0, interrupt_board}, 32'h0);

    rxd = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    chk("glitch_irq", {31'b0, interrupt_board}, 32'h0);
    chk("glitch_rx_data", rx_data, 32'h12345678);
    chk("glitch_no_fe", fe_cnt, 0);

    send_byte(8'hAA, 1'b0, 1'b0);
    chk("fe_pulse_hi", {31'b0, fe_post}, 32'h1);
    chk("fe_pulse_lo", {31'b0, fe_after}, 32'h0);
    chk("fe_irq_unchanged", {31'b0, interrupt_board}, 32'h0);
    idle(24);
    send_word(32'h04030201, 1'b0);
    chk("fe_one_pulse", fe_cnt, 1);
    chk("fe_word", rx_data, 32'h04030201);
    chk("fe_word_irq", {31'b0, interrupt_board}, 32'h1);
    pulse_clr();

    send_word(32'h11111111, 1'b0);
    chk("ov_w1", rx_data, 32'h11111111);
    send_word(32'h22222222, 1'b0);
    chk("ov_pulse_hi", {31'b0, ov_post}, 32'h1);
    chk("ov_pulse_lo", {31'b0, ov_after}, 32'h0);
    chk("ov_rx_kept", rx_data, 32'h11111111);
    chk("ov_irq_kept", {31'b0, interrupt_board}, 32'h1);
    send_word(32'h33333333, 1'b1);
    chk("clr_race_irq", {31'b0, irq_post}, 32'h1);
    chk("clr_race_no_ov", {31'b0, ov_post}, 32'h0);
    chk("clr_race_data", rx_data, 32'h33333333);
    chk("ov_count", ov_cnt, 1);

    send_byte(8'hB1, 1'b1, 1'b0);
    pd = 8'hC5;
    for (int i = 0; i < 88; i++) begin
      if (i < BD) rxd = 1'b0;
      else        rxd = pd[i/BD - 1];
      @(negedge clk);
    end
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_rx_data", rx_data, 32'h0);
    chk("midrst_irq", {31'b0, interrupt_board}, 32'h0);
    chk("midrst_fe", {31'b0, frame_err}, 32'h0);
    chk("midrst_ov", {31'b0, overrun}, 32'h0);
    rst_n = 1'b1;
    idle(5);
    send_word(32'hC4C3C2C1, 1'b0);
    chk("midrst_word", rx_data, 32'hC4C3C2C1);
    pulse_clr();

    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h66, 1'b1, 1'b0);
    idle(21 * BD);
`ifdef SPART_WORD_TIMEOUT_EN
    send_word(32'hA3A2A1A0, 1'b0);
    chk("timeout_word", rx_data, 32'hA3A2A1A0);
`else
    send_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'hA1, 1'b1, 1'b0);
    chk("held_partial_word", rx_data, 32'hA1A06655);
`endif
    chk("final_irq", {31'b0, interrupt_board}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
